gpio_bank: RTL and testbench
============================

Name: gpio_bank

Overview:
- Parametrised memory-bus GPIO slave that replaces the fixed one-input and four-output port blocks with a single block.
- Provides NOUT output registers and NIN synchronised inputs.
- Output writes support set, clear and toggle modes; inputs have sticky rising-edge flags and a level interrupt.
- Sits on the CPU memory bus behind one decoder chip-select and uses the same cs, wen, din and dout semantics as the existing bus slaves.

Parameters:
- WIDTH, 32, data width of the bus and of every port.
- NOUT, 4, number of output ports (1..8).
- NIN, 2, number of input ports (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select from the address decoder.
- wen  in  1  write enable; a write occurs when cs & wen.
- addr  in  6  register address, taken from the low bus address bits.
- din  in  WIDTH  write data from the CPU.
- dout  out  WIDTH  registered read data.
- io_in  in  NIN*WIDTH  input ports; port j occupies bits [j*WIDTH +: WIDTH].
- io_out  out  NOUT*WIDTH  output ports; port k occupies bits [k*WIDTH +: WIDTH].
- irq  out  1  registered OR of all edge-flag bits.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - OUT[k], EDGE[j], both sync stages, prev stage, dout and irq all go to 0.
  - The arm counter goes to 0.
- Address decode:
  - idx = addr[2:0]; bank = addr[3]; mode = addr[5:4].
  - bank 0: idx 0..NOUT-1 selects OUT[idx].
  - bank 1: idx 0..3 selects IN[idx]; idx 4..7 selects EDGE[idx-4].
  - Any idx >= NOUT in bank 0, or >= NIN within its half of bank 1, is unmapped: reads return 0 and writes are ignored.
- Output write (cs & wen, bank 0), applied at the clock edge:
  - mode 00: OUT <= din.
  - mode 01: OUT <= OUT | din.
  - mode 10: OUT <= OUT & ~din.
  - mode 11: OUT <= OUT ^ din.
  - io_out reflects OUT directly, with no extra stage.
- Writes to IN registers are ignored. Writes to EDGE[j] are write-1-to-clear in every mode.
- Read path:
  - dout <= selected register at every clock edge where cs=1, so data is valid one cycle after the address is presented.
  - When cs=0, dout holds its previous value.
  - Reading any register has no side effects.
  - A read and a write to the same OUT register in the same cycle returns the old value.
- Input path, per bit:
  - s1 <= io_in; s2 <= s1; p <= s2.
  - IN[j] reads s2.
  - An io_in change becomes visible in dout 3 clocks after it is sampled.
- Arming:
  - A 2-bit arm counter increments from 0 after reset release and saturates at 3.
  - Edge detection is enabled only when the counter equals 3. This suppresses false edges from inputs that are already high when reset is released.
- Edge flags:
  - When armed, EDGE[j] <= (EDGE[j] & ~clr) | (s2 & ~p), where clr is din during a W1C write to EDGE[j], else 0.
  - If a new edge and a clear hit the same bit in the same cycle, the set wins.
  - Falling edges are not flagged.
- irq is registered: irq <= |(all EDGE bits), so it follows the flags with 1 cycle of latency.
- An asynchronous reset asserted mid-operation (including during a write) aborts it; all state returns to reset values and arming restarts.

Test Plan:
- Reset and defaults: hold reset_n=0, then release. Require io_out=0, irq=0, dout=0; a read of addr 0x00 returns 0 and a read of addr 0x08 returns 0 when io_in=0.
- Write modes on OUT[1]:
  - Write 0x0000_00F0 to addr 0x01, then 0x0000_000F to addr 0x11; require OUT[1]=0x0000_00FF.
  - Write 0x0000_0030 to addr 0x21; require 0x0000_00CF.
  - Write 0x0000_00FF to addr 0x31; require 0x0000_0030.
  - OUT[0] and OUT[2] stay unchanged throughout.
- Unmapped access (NOUT=4): write 0x1234 to addr 0x05 -> no io_out change, read of 0x05 returns 0; read of addr 0x0B (IN[3], NIN=2) returns 0.
- Input sync and edge:
  - With the block armed, set io_in[3] of port 1 from 0 to 1. Require the IN[1] read (addr 0x09) to show 0x8 three clocks later, EDGE[1] (addr 0x0D) = 0x8, and irq=1 one cycle after the flag sets.
  - Drive io_in back to 0: require no new flag.
- W1C versus simultaneous edge:
  - Write 0x8 to addr 0x0D in the same cycle a new rising edge arrives on bit 3 -> EDGE[1] stays 0x8.
  - Repeat the write with no edge -> EDGE[1]=0 and irq deasserts one cycle later.
- Arming: hold io_in port 0 = 0xFFFF_FFFF through reset and its release -> EDGE[0] stays 0 and irq stays 0 indefinitely. Assert reset_n=0 mid-write -> OUT is 0 after release.

Source files
------------

// File: rtl/gpio_bank_if.sv
// CPU memory-bus slave port for gpio_bank: chip select, write enable,
// address, write data and registered read data.
interface gpio_bank_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cs;
  logic             wen;
  logic [5:0]       addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (output cs, wen, addr, din, input  dout);
  modport slave  (input  cs, wen, addr, din, output dout);
endinterface

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: NOUT set/clear/toggle output registers and NIN
// synchronised inputs with sticky rising-edge flags and a level interrupt.
module gpio_bank #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NOUT  = 4,
  parameter int unsigned NIN   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gpio_bank_if.slave            bus,
  input  logic [NIN*WIDTH-1:0]  io_in,
  output logic [NOUT*WIDTH-1:0] io_out,
  output logic                  irq
);

  logic [2:0] idx;
  logic       bank;
  logic [1:0] mode;
  logic       wr;

  logic [WIDTH-1:0] out_q  [NOUT];
  logic [WIDTH-1:0] s1_q   [NIN];
  logic [WIDTH-1:0] s2_q   [NIN];
  logic [WIDTH-1:0] p_q    [NIN];
  logic [WIDTH-1:0] edge_q [NIN];
  logic [WIDTH-1:0] clr_c  [NIN];
  logic [WIDTH-1:0] rd_c;
  logic [1:0]       arm_q;
  logic             armed;
  logic             any_edge_c;

  assign idx   = bus.addr[2:0];
  assign bank  = bus.addr[3];
  assign mode  = bus.addr[5:4];
  assign wr    = bus.cs & bus.wen;
  assign armed = (arm_q == 2'd3);

  for (genvar k = 0; k < NOUT; k++) begin : g_out
    assign io_out[k*WIDTH +: WIDTH] = out_q[k];
  end

  // Output registers; unmapped indices match no k and are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NOUT; k++) out_q[k] <= '0;
    end else if (wr && !bank) begin
      for (int k = 0; k < NOUT; k++) begin
        if (idx == 3'(k)) begin
          case (mode)
            2'b00:   out_q[k] <= bus.din;
            2'b01:   out_q[k] <= out_q[k] | bus.din;
            2'b10:   out_q[k] <= out_q[k] & ~bus.din;
            default: out_q[k] <= out_q[k] ^ bus.din;
          endcase
        end
      end
    end
  end

  // Input synchronisers and previous-value stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NIN; j++) begin
        s1_q[j] <= '0;
        s2_q[j] <= '0;
        p_q[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NIN; j++) begin
        s1_q[j] <= io_in[j*WIDTH +: WIDTH];
        s2_q[j] <= s1_q[j];
        p_q[j]  <= s2_q[j];
      end
    end
  end

  // Arm counter holds off edge detection until the sync pipeline is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    arm_q <= 2'd0;
    else if (!armed) arm_q <= arm_q + 2'd1;
  end

  always_comb begin
    for (int j = 0; j < NIN; j++) begin
      clr_c[j] = '0;
      if (wr && bank && idx[2] && (idx[1:0] == 2'(j))) clr_c[j] = bus.din;
    end
  end

  // Sticky rising-edge flags; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NIN; j++) edge_q[j] <= '0;
    end else if (armed) begin
      for (int j = 0; j < NIN; j++)
        edge_q[j] <= (edge_q[j] & ~clr_c[j]) | (s2_q[j] & ~p_q[j]);
    end
  end

  always_comb begin
    any_edge_c = 1'b0;
    for (int j = 0; j < NIN; j++) any_edge_c = any_edge_c | (|edge_q[j]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= any_edge_c;
  end

  always_comb begin
    rd_c = '0;
    if (!bank) begin
      for (int k = 0; k < NOUT; k++)
        if (idx == 3'(k)) rd_c = out_q[k];
    end else if (!idx[2]) begin
      for (int j = 0; j < NIN; j++)
        if (idx[1:0] == 2'(j)) rd_c = s2_q[j];
    end else begin
      for (int j = 0; j < NIN; j++)
        if (idx[1:0] == 2'(j)) rd_c = edge_q[j];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    bus.dout <= '0;
    else if (bus.cs) bus.dout <= rd_c;
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank with default parameters
// (WIDTH=32, NOUT=4, NIN=2).
module tb_gpio_bank;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NOUT  = 4;
  localparam int unsigned NIN   = 2;

  logic                  clk;
  logic                  reset_n;
  logic [NIN*WIDTH-1:0]  io_in;
  logic [NOUT*WIDTH-1:0] io_out;
  logic                  irq;

  int checks   = 0;
  int failures = 0;

  gpio_bank_if #(.WIDTH(WIDTH)) bus ();

  gpio_bank #(.WIDTH(WIDTH), .NOUT(NOUT), .NIN(NIN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .io_in   (io_in),
    .io_out  (io_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] out_port(input int k);
    return io_out[k*WIDTH +: WIDTH];
  endfunction

  // Called at a negedge; returns at the next negedge after the write edge.
  task automatic bus_write(input logic [5:0] a, input logic [WIDTH-1:0] d);
    bus.cs   = 1'b1;
    bus.wen  = 1'b1;
    bus.addr = a;
    bus.din  = d;
    @(negedge clk);
    bus.cs   = 1'b0;
    bus.wen  = 1'b0;
    bus.din  = '0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [WIDTH-1:0] d);
    bus.cs   = 1'b1;
    bus.wen  = 1'b0;
    bus.addr = a;
    @(negedge clk);
    bus.cs   = 1'b0;
    d        = bus.dout;
  endtask

  logic [WIDTH-1:0] rd;

  initial begin
    reset_n  = 1'b0;
    io_in    = '0;
    bus.cs   = 1'b0;
    bus.wen  = 1'b0;
    bus.addr = '0;
    bus.din  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset defaults
    check("rst_io_out0", out_port(0), 32'h0);
    check("rst_io_out3", out_port(3), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_dout", bus.dout, 32'h0);
    bus_read(6'h00, rd); check("rst_rd_out0", rd, 32'h0);
    bus_read(6'h08, rd); check("rst_rd_in0", rd, 32'h0);
    repeat (4) @(negedge clk);

    // Write modes on OUT[1], with neighbours preloaded
    bus_write(6'h00, 32'hA5A5_A5A5);
    bus_write(6'h02, 32'h5A5A_5A5A);
    bus_write(6'h01, 32'h0000_00F0);
    bus_write(6'h11, 32'h0000_000F);
    check("set_or", out_port(1), 32'h0000_00FF);
    bus_write(6'h21, 32'h0000_0030);
    check("clear", out_port(1), 32'h0000_00CF);
    bus_write(6'h31, 32'h0000_00FF);
    check("toggle", out_port(1), 32'h0000_0030);
    check("out0_kept", out_port(0), 32'hA5A5_A5A5);
    check("out2_kept", out_port(2), 32'h5A5A_5A5A);
    bus_read(6'h01, rd); check("rd_out1", rd, 32'h0000_0030);
    bus_write(6'h01, 32'h0000_0100);
    check("rw_same_old", bus.dout, 32'h0000_0030);
    check("rw_same_new", out_port(1), 32'h0000_0100);

    // Unmapped accesses
    bus_write(6'h05, 32'h0000_1234);
    check("unmap_out0", out_port(0), 32'hA5A5_A5A5);
    check("unmap_out1", out_port(1), 32'h0000_0100);
    check("unmap_out2", out_port(2), 32'h5A5A_5A5A);
    check("unmap_out3", out_port(3), 32'h0);
    bus_read(6'h05, rd); check("unmap_rd05", rd, 32'h0);
    bus_read(6'h0B, rd); check("unmap_rd0b", rd, 32'h0);
    bus_write(6'h08, 32'hFFFF_FFFF);
    bus_read(6'h08, rd); check("in_wr_ignored", rd, 32'h0);

    // Input sync latency and rising edge on port 1 bit 3
    io_in[WIDTH +: WIDTH] = 32'h8;
    bus.cs   = 1'b1;
    bus.wen  = 1'b0;
    bus.addr = 6'h09;
    @(negedge clk); check("sync_c1", bus.dout, 32'h0);
    @(negedge clk); check("sync_c2", bus.dout, 32'h0);
    @(negedge clk); check("sync_c3", bus.dout, 32'h8);
    check("irq_lat0", 32'(irq), 32'h0);
    @(negedge clk); check("irq_lat1", 32'(irq), 32'h1);
    bus.cs = 1'b0;
    bus_read(6'h0D, rd); check("edge1_set", rd, 32'h8);
    bus_read(6'h0C, rd); check("edge0_clear", rd, 32'h0);

    // Falling edge does not set anything new
    io_in = '0;
    repeat (6) @(negedge clk);
    bus_read(6'h0D, rd); check("fall_edge1", rd, 32'h8);
    bus_read(6'h0C, rd); check("fall_edge0", rd, 32'h0);

    // W1C in the same cycle as a new rising edge: set wins
    io_in[WIDTH +: WIDTH] = 32'h8;
    @(negedge clk);
    @(negedge clk);
    bus_write(6'h0D, 32'h8);
    bus_read(6'h0D, rd); check("w1c_vs_edge", rd, 32'h8);

    // W1C with no edge clears; irq drops one cycle later (mode bits ignored)
    bus_write(6'h2D, 32'h8);
    check("irq_after_clr", 32'(irq), 32'h1);
    bus_read(6'h0D, rd); check("w1c_clear", rd, 32'h0);
    check("irq_dropped", 32'(irq), 32'h0);

    // Held-high input through reset, and reset asserted mid-write
    io_in = '0;
    io_in[0 +: WIDTH] = 32'hFFFF_FFFF;
    bus_write(6'h03, 32'h0000_0077);
    check("pre_rst_out3", out_port(3), 32'h0000_0077);
    bus.cs   = 1'b1;
    bus.wen  = 1'b1;
    bus.addr = 6'h02;
    bus.din  = 32'hDEAD_BEEF;
    #2 reset_n = 1'b0;
    @(negedge clk);
    bus.cs  = 1'b0;
    bus.wen = 1'b0;
    bus.din = '0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_out0", out_port(0), 32'h0);
    check("midrst_out1", out_port(1), 32'h0);
    check("midrst_out2", out_port(2), 32'h0);
    check("midrst_out3", out_port(3), 32'h0);
    repeat (20) @(negedge clk);
    bus_read(6'h0C, rd); check("arm_edge0", rd, 32'h0);
    check("arm_irq", 32'(irq), 32'h0);
    bus_read(6'h08, rd); check("arm_in0", rd, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    check("arm_irq_late", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
